// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared constants for the register file and its scoreboard
package reg_file_sb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NREGS      = 32;
   localparam int DATA_W     = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   // True when the address names a real, writable register.
   function automatic logic addr_live(input logic [REG_ADDR_W-1:0] addr, input int nregs);
      return (addr != ZERO_REG) && (int'(addr) < nregs);
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending bits and source busy compare
module reg_scoreboard #(
   parameter int NREGS = reg_file_sb_pkg::NREGS
) (
   input  logic                                  i_clk,
   input  logic                                  i_reset,
   input  logic                                  i_issue_valid,
   input  logic [reg_file_sb_pkg::REG_ADDR_W-1:0] i_issue_dst,
   input  logic                                  i_clr_valid,
   input  logic [reg_file_sb_pkg::REG_ADDR_W-1:0] i_clr_dst,
   input  logic [reg_file_sb_pkg::REG_ADDR_W-1:0] i_src1,
   input  logic [reg_file_sb_pkg::REG_ADDR_W-1:0] i_src2,
   output logic                                  o_busy1,
   output logic                                  o_busy2
);
   import reg_file_sb_pkg::*;

   logic [NREGS-1:0] r_pending;
   logic [NREGS-1:0] w_set;
   logic [NREGS-1:0] w_clr;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (i_issue_valid && addr_live(i_issue_dst, NREGS)) begin
         w_set[i_issue_dst] = 1'b1;
      end
      if (i_clr_valid && addr_live(i_clr_dst, NREGS)) begin
         w_clr[i_clr_dst] = 1'b1;
      end
   end

   // Set is applied after clear so a new producer issued on the retiring edge keeps the bit.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_set;
      end
   end

   always_comb begin
      o_busy1 = 1'b0;
      o_busy2 = 1'b0;
      if (addr_live(i_src1, NREGS)) begin
         o_busy1 = r_pending[i_src1];
      end
      if (addr_live(i_src2, NREGS)) begin
         o_busy2 = r_pending[i_src2];
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with hazard scoreboard; REG_FILE_BYPASS_EN adds write-to-read bypass
module reg_file_sb #(
   parameter int DATA_W = reg_file_sb_pkg::DATA_W,
   parameter int NREGS  = reg_file_sb_pkg::NREGS
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [reg_file_sb_pkg::REG_ADDR_W-1:0] readReg1,
   input  logic [reg_file_sb_pkg::REG_ADDR_W-1:0] readReg2,
   output logic [DATA_W-1:0]                     readData1,
   output logic [DATA_W-1:0]                     readData2,
   input  logic [reg_file_sb_pkg::REG_ADDR_W-1:0] writeReg,
   input  logic [DATA_W-1:0]                     writeData,
   input  logic                                  regWrite,
   input  logic                                  issueValid,
   input  logic [reg_file_sb_pkg::REG_ADDR_W-1:0] issueDst,
   output logic                                  hazard,
   input  logic [reg_file_sb_pkg::REG_ADDR_W-1:0] dbgReg,
   output logic [DATA_W-1:0]                     dbgData
);
   import reg_file_sb_pkg::*;

   logic [DATA_W-1:0] r_regs [NREGS];
   logic              w_wr_live;
   logic              w_busy1;
   logic              w_busy2;
   logic              w_byp1;
   logic              w_byp2;
   logic              w_bypd;

   assign w_wr_live = regWrite && addr_live(writeReg, NREGS);

   // Entry 0 is cleared on reset and never written, but reads of it are gated to zero anyway.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_live) begin
         r_regs[writeReg] <= writeData;
      end
   end

   function automatic logic [DATA_W-1:0] stored(input logic [REG_ADDR_W-1:0] addr);
      logic [DATA_W-1:0] v;
      v = '0;
      if (addr_live(addr, NREGS)) begin
         v = r_regs[addr];
      end
      return v;
   endfunction

`ifdef REG_FILE_BYPASS_EN
   assign w_byp1 = w_wr_live && (writeReg == readReg1);
   assign w_byp2 = w_wr_live && (writeReg == readReg2);
   assign w_bypd = w_wr_live && (writeReg == dbgReg);
`else
   assign w_byp1 = 1'b0;
   assign w_byp2 = 1'b0;
   assign w_bypd = 1'b0;
`endif

   always_comb begin
      readData1 = w_byp1 ? writeData : stored(readReg1);
      readData2 = w_byp2 ? writeData : stored(readReg2);
      dbgData   = w_bypd ? writeData : stored(dbgReg);
   end

   reg_scoreboard #(
      .NREGS(NREGS)
   ) u_scoreboard (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_issue_valid(issueValid),
      .i_issue_dst  (issueDst),
      .i_clr_valid  (regWrite),
      .i_clr_dst    (writeReg),
      .i_src1       (readReg1),
      .i_src2       (readReg2),
      .o_busy1      (w_busy1),
      .o_busy2      (w_busy2)
   );

   // A bypassed source already has its value this cycle, so it cannot stall.
   assign hazard = (w_busy1 && !w_byp1) || (w_busy2 && !w_byp2);

endmodule
